// File: rtl/bus_pkg.sv
// Shared bus constants, slave FSM state encoding and address-step helper.
package bus_pkg;

    localparam int ADDR_WIDTH  = 12;
    localparam int DATA_WIDTH  = 8;
    localparam int BURST_WIDTH = 13;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RX_HDR  = 3'd1,
        WR_DATA = 3'd2,
        WR_ACK  = 3'd3,
        RD_DATA = 3'd4
    } state_e;

    // Incrementing bursts wrap naturally at the top of the address space.
    function automatic logic [ADDR_WIDTH-1:0] next_addr(input logic [ADDR_WIDTH-1:0] addr,
                                                        input logic                  incr);
        logic [ADDR_WIDTH-1:0] step;
        step = {{(ADDR_WIDTH-1){1'b0}}, incr};
        return addr + step;
    endfunction

endpackage

// File: rtl/slave_mem.sv
// Single-port byte memory: synchronous write, combinational read, contents survive reset.
module slave_mem
    import bus_pkg::*;
(
    input  logic                  clk,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] mem_q [2**ADDR_WIDTH];

    assign rdata = mem_q[addr];

    // Byte store on write strobe.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[addr] <= wdata;
        end
    end

endmodule

// File: rtl/slave.sv
// Serial system-bus slave: LSB-first header/data on three lanes, byte memory,
// serial read-return lane with master_ready back-pressure.
module slave
    import bus_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic read_en,
    input  logic write_en,
    input  logic master_valid,
    input  logic master_ready,
    input  logic rx_address,
    input  logic rx_data,
    input  logic rx_burst,
    output logic slave_valid,
    output logic slave_ready,
    output logic tx_data
);

    localparam int CNT_W = $clog2(BURST_WIDTH + 1);
    localparam int BIT_W = $clog2(DATA_WIDTH);
    localparam logic [CNT_W-1:0] HDR_LAST = CNT_W'(BURST_WIDTH - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_WIDTH - 1);

    state_e                 state_q, state_d;
    logic [CNT_W-1:0]       hdr_cnt_q, hdr_cnt_d;
    logic [ADDR_WIDTH-1:0]  addr_q, addr_d;
    logic [ADDR_WIDTH-1:0]  cur_addr_q, cur_addr_d;
    logic [BURST_WIDTH-2:0] burst_q, burst_d;
    logic [BURST_WIDTH-2:0] beats_rem_q, beats_rem_d;
    logic [DATA_WIDTH-2:0]  data_sr_q, data_sr_d;
    logic [DATA_WIDTH-1:0]  hold_q, hold_d;
    logic [DATA_WIDTH-1:0]  tx_sr_q, tx_sr_d;
    logic [BIT_W-1:0]       dcnt_q, dcnt_d;
    logic [BIT_W-1:0]       tx_cnt_q, tx_cnt_d;
    logic                   is_wr_q, is_wr_d;
    logic                   incr_q, incr_d;
    logic                   slave_valid_q, slave_valid_d;
    logic                   slave_ready_q, slave_ready_d;

    logic                   accept_s;
    logic                   mem_we_s;
    logic [ADDR_WIDTH-1:0]  mem_addr_s;
    logic [DATA_WIDTH-1:0]  mem_rdata_s;
    logic [DATA_WIDTH-1:0]  rx_byte_s;

    assign accept_s    = master_valid && slave_ready_q;
    assign rx_byte_s   = {rx_data, data_sr_q};
    assign mem_we_s    = (state_q == WR_ACK) && !reset;
    assign slave_valid = slave_valid_q;
    assign slave_ready = slave_ready_q;
    assign tx_data     = tx_sr_q[0];

    slave_mem u_mem (
        .clk   (clk),
        .we    (mem_we_s),
        .addr  (mem_addr_s),
        .wdata (hold_q),
        .rdata (mem_rdata_s)
    );

    // Read port looks ahead to the byte that will be loaded at the next edge.
    always_comb begin
        mem_addr_s = cur_addr_q;
        case (state_q)
            RX_HDR:  mem_addr_s = addr_q;
            RD_DATA: mem_addr_s = next_addr(cur_addr_q, incr_q);
            default: mem_addr_s = cur_addr_q;
        endcase
    end

    // Next-state, datapath and registered-output computation.
    always_comb begin
        state_d     = state_q;
        hdr_cnt_d   = hdr_cnt_q;
        addr_d      = addr_q;
        cur_addr_d  = cur_addr_q;
        burst_d     = burst_q;
        beats_rem_d = beats_rem_q;
        data_sr_d   = data_sr_q;
        hold_d      = hold_q;
        tx_sr_d     = tx_sr_q;
        dcnt_d      = dcnt_q;
        tx_cnt_d    = tx_cnt_q;
        is_wr_d     = is_wr_q;
        incr_d      = incr_q;

        case (state_q)
            IDLE: begin
                if (accept_s && (write_en || read_en)) begin
                    is_wr_d   = write_en;
                    hdr_cnt_d = CNT_W'(1);
                    addr_d    = {rx_address, addr_q[ADDR_WIDTH-1:1]};
                    burst_d   = {rx_burst, burst_q[BURST_WIDTH-2:1]};
                    data_sr_d = {rx_data, data_sr_q[DATA_WIDTH-2:1]};
                    dcnt_d    = BIT_W'(1);
                    state_d   = RX_HDR;
                end else begin
                    state_d = IDLE;
                end
            end
            RX_HDR: begin
                if (accept_s) begin
                    hdr_cnt_d = hdr_cnt_q + CNT_W'(1);
                    data_sr_d = {rx_data, data_sr_q[DATA_WIDTH-2:1]};
                    dcnt_d    = dcnt_q + BIT_W'(1);
                    if (dcnt_q == BIT_LAST) begin
                        hold_d = rx_byte_s;
                    end else begin
                        hold_d = hold_q;
                    end
                    // Address is complete one bit before the burst field.
                    if (hdr_cnt_q == HDR_LAST) begin
                        cur_addr_d  = addr_q;
                        beats_rem_d = burst_q;
                        incr_d      = rx_burst;
                        if (is_wr_q) begin
                            state_d = WR_ACK;
                        end else begin
                            state_d  = RD_DATA;
                            tx_sr_d  = mem_rdata_s;
                            tx_cnt_d = '0;
                        end
                    end else begin
                        addr_d  = {rx_address, addr_q[ADDR_WIDTH-1:1]};
                        burst_d = {rx_burst, burst_q[BURST_WIDTH-2:1]};
                        state_d = RX_HDR;
                    end
                end else begin
                    state_d = RX_HDR;
                end
            end
            WR_DATA: begin
                if (accept_s) begin
                    data_sr_d = {rx_data, data_sr_q[DATA_WIDTH-2:1]};
                    dcnt_d    = dcnt_q + BIT_W'(1);
                    if (dcnt_q == BIT_LAST) begin
                        hold_d  = rx_byte_s;
                        state_d = WR_ACK;
                    end else begin
                        state_d = WR_DATA;
                    end
                end else begin
                    state_d = WR_DATA;
                end
            end
            WR_ACK: begin
                if (beats_rem_q == '0) begin
                    state_d = IDLE;
                end else begin
                    beats_rem_d = beats_rem_q - (BURST_WIDTH-1)'(1);
                    cur_addr_d  = next_addr(cur_addr_q, incr_q);
                    state_d     = WR_DATA;
                end
            end
            RD_DATA: begin
                if (master_ready) begin
                    if (tx_cnt_q == BIT_LAST) begin
                        if (beats_rem_q == '0) begin
                            tx_sr_d = '0;
                            state_d = IDLE;
                        end else begin
                            beats_rem_d = beats_rem_q - (BURST_WIDTH-1)'(1);
                            cur_addr_d  = next_addr(cur_addr_q, incr_q);
                            tx_sr_d     = mem_rdata_s;
                            tx_cnt_d    = '0;
                            state_d     = RD_DATA;
                        end
                    end else begin
                        tx_sr_d  = {1'b0, tx_sr_q[DATA_WIDTH-1:1]};
                        tx_cnt_d = tx_cnt_q + BIT_W'(1);
                        state_d  = RD_DATA;
                    end
                end else begin
                    state_d = RD_DATA;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        slave_ready_d = (state_d == IDLE) || (state_d == RX_HDR) || (state_d == WR_DATA);
        slave_valid_d = (state_d == WR_ACK) || (state_d == RD_DATA);
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= IDLE;
            hdr_cnt_q     <= '0;
            addr_q        <= '0;
            cur_addr_q    <= '0;
            burst_q       <= '0;
            beats_rem_q   <= '0;
            data_sr_q     <= '0;
            hold_q        <= '0;
            tx_sr_q       <= '0;
            dcnt_q        <= '0;
            tx_cnt_q      <= '0;
            is_wr_q       <= 1'b0;
            incr_q        <= 1'b0;
            slave_valid_q <= 1'b0;
            slave_ready_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            hdr_cnt_q     <= hdr_cnt_d;
            addr_q        <= addr_d;
            cur_addr_q    <= cur_addr_d;
            burst_q       <= burst_d;
            beats_rem_q   <= beats_rem_d;
            data_sr_q     <= data_sr_d;
            hold_q        <= hold_d;
            tx_sr_q       <= tx_sr_d;
            dcnt_q        <= dcnt_d;
            tx_cnt_q      <= tx_cnt_d;
            is_wr_q       <= is_wr_d;
            incr_q        <= incr_d;
            slave_valid_q <= slave_valid_d;
            slave_ready_q <= slave_ready_d;
        end
    end

endmodule

// File: tb/tb_slave.sv
// Directed bench for the serial bus slave: writes, bursts with wrap, reads, stalls, aborts.
module tb_slave;

    logic clk;
    logic reset;
    logic read_en, write_en, master_valid, master_ready;
    logic rx_address, rx_data, rx_burst;
    logic slave_valid, slave_ready, tx_data;

    int checks = 0;
    int errors = 0;

    slave dut (
        .clk          (clk),
        .reset        (reset),
        .read_en      (read_en),
        .write_en     (write_en),
        .master_valid (master_valid),
        .master_ready (master_ready),
        .rx_address   (rx_address),
        .rx_data      (rx_data),
        .rx_burst     (rx_burst),
        .slave_valid  (slave_valid),
        .slave_ready  (slave_ready),
        .tx_data      (tx_data)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic go_idle();
        master_valid = 1'b0;
        write_en     = 1'b0;
        read_en      = 1'b0;
        master_ready = 1'b1;
        rx_address   = 1'b0;
        rx_data      = 1'b0;
        rx_burst     = 1'b0;
    endtask

    // Drives one transaction bit by bit; enables are flipped after the first bit.
    task automatic run_txn(input logic wr, input logic [11:0] a, input logic [12:0] b,
                           input logic [15:0] d, input int beats, input int hdr_stall_k,
                           input int rd_stall_at, input int rst_at, input string tag,
                           input logic [15:0] exp_rx, input int exp_first);
        int k, cyc, total, pulses, first, n_rx, hs, rs;
        logic [15:0] rx_bits;
        logic acc, done, aborted;
        total   = wr ? ((beats * 8 > 13) ? beats * 8 : 13) : 13;
        k = 0; cyc = 0; pulses = 0; first = -1; n_rx = 0; hs = 0; rs = 0;
        rx_bits = 16'h0000; done = 1'b0; aborted = 1'b0;
        while (!done && !aborted && cyc < 300) begin
            if (k == hdr_stall_k && hs < 2) begin
                master_valid = 1'b0;
                hs++;
            end else begin
                master_valid = (k < total);
            end
            rx_address = (k < 12) ? a[k] : 1'b0;
            rx_burst   = (k < 13) ? b[k] : 1'b0;
            rx_data    = wr ? ((k < 16) ? d[k] : 1'b0) : 1'b1;
            write_en   = (k == 0) ? wr : !wr;
            read_en    = (k == 0) ? !wr : wr;
            if (!wr && n_rx == rd_stall_at && rs < 3) begin
                master_ready = 1'b0;
                rs++;
            end else begin
                master_ready = 1'b1;
            end
            if (k == rst_at) begin
                reset = 1'b1;
                tick();
                reset = 1'b0;
                go_idle();
                aborted = 1'b1;
            end else begin
                if (slave_valid && first < 0) first = cyc;
                if (wr && slave_valid) pulses++;
                if (!wr && slave_valid && master_ready && n_rx < 16) begin
                    rx_bits[n_rx] = tx_data;
                    n_rx++;
                end
                done = wr ? (pulses == beats) : (n_rx == beats * 8);
                if (!done) begin
                    acc = master_valid && slave_ready;
                    tick();
                    cyc++;
                    if (acc) k++;
                end
            end
        end
        if (aborted) begin
            check({tag, "_valid_after_rst"}, 32'(slave_valid), 32'd0);
            pulses = 0;
            for (int i = 0; i < 20; i++) begin
                if (slave_valid) pulses++;
                tick();
            end
            check({tag, "_no_pulse"}, 32'(pulses), 32'd0);
            check({tag, "_ready_idle"}, 32'(slave_ready), 32'd1);
        end else begin
            check({tag, "_done"}, 32'(done), 32'd1);
            check({tag, "_first"}, 32'(first), 32'(exp_first));
            if (wr) begin
                check({tag, "_pulses"}, 32'(pulses), 32'(beats));
            end else begin
                check({tag, "_rxdata"}, 32'(rx_bits), 32'(exp_rx));
            end
            go_idle();
            tick();
            check({tag, "_post_ready"}, 32'(slave_ready), 32'd1);
            check({tag, "_post_valid"}, 32'(slave_valid), 32'd0);
            check({tag, "_post_tx"}, 32'(tx_data), 32'd0);
        end
    endtask

    initial begin
        go_idle();
        reset = 1'b1;
        repeat (3) tick();
        check("rst_ready", 32'(slave_ready), 32'd0);
        check("rst_valid", 32'(slave_valid), 32'd0);
        check("rst_tx", 32'(tx_data), 32'd0);
        reset = 1'b0;
        tick();
        check("rst_release_ready", 32'(slave_ready), 32'd1);
        tick();

        // Single write, then two-beat incrementing write wrapping 0xFFF -> 0x000.
        run_txn(1'b1, 12'hADD, 13'h0000, 16'h00BD, 1, -1, -1, -1, "wr_single", 16'h0000, 13);
        run_txn(1'b1, 12'hFFF, 13'h1001, 16'h2211, 2, -1, -1, -1, "wr_wrap", 16'h0000, 13);

        // Bits with neither enable set are discarded.
        write_en = 1'b0; read_en = 1'b0; master_valid = 1'b1; rx_address = 1'b1; rx_burst = 1'b1;
        repeat (4) tick();
        check("discard_valid", 32'(slave_valid), 32'd0);
        check("discard_ready", 32'(slave_ready), 32'd1);
        go_idle();
        tick();

        run_txn(1'b0, 12'hADD, 13'h0000, 16'h0000, 1, -1, -1, -1, "rd_single", 16'h00BD, 13);
        run_txn(1'b0, 12'hFFF, 13'h1001, 16'h0000, 2, -1, -1, -1, "rd_wrap", 16'h2211, 13);

        // Fixed-address burst: the second beat overwrites the first.
        run_txn(1'b1, 12'h200, 13'h0001, 16'h55AA, 2, -1, -1, -1, "wr_fixed", 16'h0000, 13);
        run_txn(1'b0, 12'h200, 13'h0001, 16'h0000, 2, -1, -1, -1, "rd_fixed", 16'h5555, 13);

        // Header stall pushes the ack by two cycles; read stall must not change data.
        run_txn(1'b1, 12'h123, 13'h0000, 16'h003C, 1, 5, -1, -1, "wr_stall", 16'h0000, 15);
        run_txn(1'b0, 12'h123, 13'h0000, 16'h0000, 1, -1, 3, -1, "rd_stall", 16'h003C, 13);
        run_txn(1'b0, 12'hADD, 13'h0000, 16'h0000, 1, 4, 5, -1, "rd_stall2", 16'h00BD, 15);

        // Reset during header bit 6 of a write must leave memory untouched.
        run_txn(1'b1, 12'h010, 13'h0000, 16'h005A, 1, -1, -1, -1, "wr_pre", 16'h0000, 13);
        run_txn(1'b1, 12'h010, 13'h0000, 16'h00FF, 1, -1, -1, 6, "abort", 16'h0000, 0);
        run_txn(1'b0, 12'h010, 13'h0000, 16'h0000, 1, -1, -1, -1, "rd_abort", 16'h005A, 13);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
